itof_sched: RTL and testbench
=============================

# itof_sched

Round-robin scheduler that shares one pipelined int-to-float converter (fixed 4-cycle latency, `en`-gated, pipeline zeroed when `en` is low) among `N_REQ` requesters. It accepts at most one signed 32-bit integer per cycle and keeps the converter enabled while operations are in flight. Each result goes back out on a broadcast result port, tagged with the requester's ID. It sits between the shader/vertex units that need int-to-float conversion and the single converter instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LAT`, 4: converter latency in cycles from operand sampled to `q` valid.
- `ID_W`, `$clog2(N_REQ)`: width of the requester tag.

- `clk` in 1: single clock; all state on rising edge.
- `areset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `N_REQ`: requester i has an operand.
- `req_data` in `N_REQ`x32: signed integer operand per requester.
- `req_ready` out `N_REQ`: one-hot grant; the operand is accepted when valid&&ready.
- `res_valid` out 1: registered single-cycle result strobe; no backpressure.
- `res_id` out `ID_W`: tag of the requester that owns `res_data`.
- `res_data` out 32: IEEE-754 single result.
- `cvt_en` out 1: converter enable.
- `cvt_a` out 32: converter operand.
- `cvt_q` in 32: converter result.
- `busy` out 1: any operation in flight or at `res_*`.

## Operation
- Arbitration: round-robin. The search starts at `rr_ptr+1` mod `N_REQ`. The first i with `req_valid[i]` is granted: `req_ready[i]=1`, combinational, at most one bit set. On a grant, `rr_ptr<=i`; otherwise `rr_ptr` holds. Reset value of `rr_ptr` is `N_REQ-1`, so requester 0 wins first.
- Issue: `cvt_a = req_data[grant]` when a grant exists, else 0.
- Tag pipeline: a `LAT`-deep shift register of {vld, id}. Stage 0 captures {issue, grant_id} every cycle; each later stage shifts unconditionally.
- Enable: `cvt_en = issue || (|vld[0..LAT-1])`.
  - `cvt_en` stays high through the cycle in which the last in-flight result is on `cvt_q`.
  - It drops to 0 the cycle after the pipeline empties with no new issue.
  - Bubbles issued while `cvt_en` is high carry vld=0.
- Retire: when `vld[LAT-1]=1`, register `res_valid<=1`, `res_id<=id[LAT-1]`, `res_data<=cvt_q`. Otherwise `res_valid<=0`. `res_id` and `res_data` hold their last values.
- `busy = (|vld) || res_valid`.
- Ordering: results retire in issue order. A requester may have up to `LAT` operations in flight.
- Conversion rounding and exceptions belong to the converter. The scheduler never alters data.

## Timing
- Reset (async assert, sync release): `rr_ptr=N_REQ-1`, all vld=0, ids=0, `res_valid=0`, `res_id=0`, `res_data=0`. This gives `cvt_en=0` and `busy=0`. `req_ready` and `cvt_a` are 0 unless `req_valid` is asserted.
- Latency: operand accepted in cycle t → converter output in cycle t+`LAT` → `res_valid` in cycle t+`LAT`+1.
- Throughput: one accept per cycle, sustained, with no gaps between back-to-back grants.
- Simultaneous issue and retire in the same cycle: both proceed independently.
- `cvt_en` never drops while any vld bit is set. Dropping it would zero the converter pipeline and lose data.
- Reset mid-operation: all in-flight operations are discarded and no `res_valid` follows. The converter sees `cvt_en=0` immediately and is cleared.
- Requester deasserting `req_valid` without a grant is legal and has no effect.

## Structure
- Shared package `itof_sched_pkg`:
  - `ITOF_LAT=4`.
  - Tag pipeline struct `itof_tag_t` {logic vld; logic [ID_W-1:0] id}.
  - Default `N_REQ`.
- Sub-module `rr_arbiter`: parameterized N, with `req`, `grant` (one-hot), `grant_id` and an `advance` input. It owns `rr_ptr` and is reusable by other shared FP units.
- Top level: the tag shift register, enable logic, result register and operand mux. The converter is instantiated outside this block by the parent.

## Test plan
- Single op: `req_valid[2]=1`, `req_data[2]=-7` at cycle 0. Expect `req_ready=4'b0100` at cycle 0, `cvt_en` high cycles 0–4, `res_valid` at cycle 5 with `res_id=2` and `res_data=32'hC0E00000`, then `cvt_en=0` at cycle 5.
- Fairness: all four requesters valid continuously for 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3, and results retiring on cycles 5–12 with ids in the same order.
- Bubbles: issue at cycles 0 and 2 only. Expect `cvt_en` high continuously for cycles 0–6, `res_valid` at cycles 5 and 7 only, and no spurious result at cycle 6.
- Burst from one requester: `req_valid[1]` high for 6 cycles with data 0,1,…,5. Expect 6 consecutive results `0x00000000`, `0x3F800000`, `0x40000000`, `0x40400000`, `0x40800000`, `0x40A00000`, all with `res_id=1`.
- Reset mid-flight: issue at cycles 0–2, assert `areset_n=0` at cycle 3. Expect `cvt_en=0` and `busy=0` immediately, and no `res_valid` afterwards. After release, the next grant goes to requester 0 first.

Source files
------------

// File: rtl/itof_sched_pkg.sv
// Shared definitions for the int-to-float scheduler:
// converter latency, default requester count and tag struct.
package itof_sched_pkg;

    localparam int ITOF_LAT      = 4;
    localparam int ITOF_N_REQ    = 4;
    // Tag width sized for the largest supported requester count (8).
    localparam int ITOF_ID_MAX_W = 3;

    typedef struct packed {
        logic                     vld;
        logic [ITOF_ID_MAX_W-1:0] id;
    } itof_tag_t;

endpackage

// File: rtl/itof_sched_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and encoded grant id.
// Ports: clk, areset_n, req[N], advance -> grant[N], grant_id.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] rr_ptr;
    logic            found;
    int              idx;

    // Search starts one past the last winner, wrapping at N.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                 = 1'b1;
                grant[idx[ID_W-1:0]]  = 1'b1;
                grant_id              = idx[ID_W-1:0];
            end
        end
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr <= ID_W'(N - 1);
        end else if (advance && found) begin
            rr_ptr <= grant_id;
        end
    end

endmodule

// File: rtl/itof_sched.sv
// Shares one pipelined int-to-float converter among N_REQ requesters.
// Ports: req_valid/req_data/req_ready (requesters), res_valid/res_id/
// res_data (broadcast result), cvt_en/cvt_a/cvt_q (converter), busy.
module itof_sched
    import itof_sched_pkg::*;
#(
    parameter int N_REQ = ITOF_N_REQ,
    parameter int LAT   = ITOF_LAT,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*32-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic              res_valid,
    output logic [ID_W-1:0]   res_id,
    output logic [31:0]       res_data,
    output logic              cvt_en,
    output logic [31:0]       cvt_a,
    input  logic [31:0]       cvt_q,
    output logic              busy
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             issue;
    logic             any_vld;
    itof_tag_t        tag [LAT];

    // No downstream stall exists, so every grant is an accept.
    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk      (clk),
        .areset_n (areset_n),
        .req      (req_valid),
        .advance  (1'b1),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign issue     = |grant;

    always_comb begin
        cvt_a = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                cvt_a = req_data[i*32 +: 32];
            end
        end
    end

    // Tag pipeline tracks the converter stages one for one.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int k = 0; k < LAT; k++) begin
                tag[k] <= '0;
            end
        end else begin
            tag[0].vld <= issue;
            tag[0].id  <= ITOF_ID_MAX_W'(grant_id);
            for (int k = 1; k < LAT; k++) begin
                tag[k] <= tag[k-1];
            end
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            any_vld = any_vld | tag[k].vld;
        end
    end

    // Holding enable while any stage is live keeps the converter
    // from zeroing an operation that is still in flight.
    assign cvt_en = issue || any_vld;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else if (tag[LAT-1].vld) begin
            res_valid <= 1'b1;
            res_id    <= tag[LAT-1].id[ID_W-1:0];
            res_data  <= cvt_q;
        end else begin
            res_valid <= 1'b0;
        end
    end

    assign busy = any_vld || res_valid;

endmodule

// File: tb/tb_itof_sched.sv
// Scoreboard bench for itof_sched with a behavioural 4-stage
// int-to-float converter standing in for the real one.
module tb_itof_sched;

    logic         clk = 1'b0;
    logic         areset_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [1:0]   res_id;
    logic [31:0]  res_data;
    logic         cvt_en;
    logic [31:0]  cvt_a;
    logic [31:0]  cvt_q;
    logic         busy;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int t;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb [$];

    itof_sched dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .cvt_en    (cvt_en),
        .cvt_a     (cvt_a),
        .cvt_q     (cvt_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural converter: round-to-nearest-even int to float.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] mag;
        logic [31:0] m;
        logic [31:0] rem;
        logic [31:0] half;
        int          p;
        int          sh;
        if (x == 32'd0) return 32'd0;
        s   = x[31];
        mag = s ? (~x + 32'd1) : x;
        p   = 31;
        while (!mag[p]) p--;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 32'd1;
            if (m[24]) begin
                m = m >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(127 + p), m[22:0]};
    endfunction

    logic [31:0] cp [4];
    always @(posedge clk) begin
        if (!cvt_en) begin
            for (int k = 0; k < 4; k++) cp[k] <= '0;
        end else begin
            cp[0] <= i2f(cvt_a);
            for (int k = 1; k < 4; k++) cp[k] <= cp[k-1];
        end
    end
    assign cvt_q = cp[3];

    // Result monitor: every res_valid must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid === 1'b1) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL spurious_res: got id=%0d data=%h cyc=%0d, none expected",
                         res_id, res_data, cyc);
            end else begin
                e = sb.pop_front();
                if (res_id !== 2'(e.id) || res_data !== e.data || cyc != e.cyc) begin
                    errs++;
                    $display("FAIL result: got id=%0d data=%h cyc=%0d, want id=%0d data=%h cyc=%0d",
                             res_id, res_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [31:0] d, input int c);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        drain();
        areset_n  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) tick();
        areset_n = 1'b1;
        tick();
    endtask

    logic [31:0] fair_f [4];
    logic [31:0] burst_f [6];

    initial begin
        fair_f  = '{32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000};
        burst_f = '{32'h00000000, 32'h3F800000, 32'h40000000,
                    32'h40400000, 32'h40800000, 32'h40A00000};

        // Reset state
        repeat (2) tick();
        areset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_en", 32'(cvt_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cvt_a", cvt_a, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_data", res_data, 32'd0);

        // Single op from requester 2
        tick();
        t = cyc;
        req_valid = 4'b0100;
        req_data[64 +: 32] = -32'sd7;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        chk("t1_cvt_a", cvt_a, 32'hFFFFFFF9);
        chk("t1_en0", 32'(cvt_en), 32'd1);
        push(2, 32'hC0E00000, t + 5);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t1_en_hi", 32'(cvt_en), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("t1_en_lo", 32'(cvt_en), 32'd0);
        chk("t1_busy_res", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Fairness: all requesters valid for 8 cycles
        do_reset();
        t = cyc;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'(10 + i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_grant", 32'(req_ready), 32'd1 << (k % 4));
            push(k % 4, fair_f[k % 4], t + k + 5);
            tick();
        end
        req_valid = '0;

        // Bubbles: issues at cycles 0 and 2 only
        do_reset();
        t = cyc;
        req_valid = 4'b0001;
        req_data[31:0] = 32'd3;
        @(negedge clk);
        chk("bub_en0", 32'(cvt_en), 32'd1);
        push(0, 32'h40400000, t + 5);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bub_en1", 32'(cvt_en), 32'd1);
        tick();
        req_valid = 4'b0001;
        req_data[31:0] = 32'd4;
        @(negedge clk);
        chk("bub_en2", 32'(cvt_en), 32'd1);
        push(0, 32'h40800000, t + 7);
        tick();
        req_valid = '0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            chk("bub_en_hi", 32'(cvt_en), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("bub_en7", 32'(cvt_en), 32'd0);

        // Burst from requester 1
        do_reset();
        t = cyc;
        req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            req_data[32 +: 32] = 32'(k);
            @(negedge clk);
            chk("burst_ready", 32'(req_ready), 32'b0010);
            push(1, burst_f[k], t + k + 5);
            tick();
        end
        req_valid = '0;

        // Reset mid-flight: issued ops must vanish
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            req_data[32 +: 32] = 32'(k + 1);
            tick();
        end
        areset_n  = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_en", 32'(cvt_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        areset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_idle", 32'(busy), 32'd0);
            tick();
        end
        t = cyc;
        req_valid = 4'b0111;
        req_data[31:0]  = 32'd100;
        req_data[63:32] = 32'd5;
        req_data[95:64] = 32'd6;
        @(negedge clk);
        chk("mid_first", 32'(req_ready), 32'b0001);
        push(0, 32'h42C80000, t + 5);
        tick();
        req_valid = '0;

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
